// File: rtl/ac97_frame_packer_if.sv
// ac97_frame_packer_if: PCM sample and codec register-write handshake channels into the AC97 frame packer.
interface ac97_frame_packer_if #(
    parameter int CHANNELS     = 2,
    parameter int SAMPLE_WIDTH = 20
);
    logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_data;
    logic                             sample_valid;
    logic                             sample_ready;
    logic [6:0]                       cmd_addr;
    logic [15:0]                      cmd_data;
    logic                             cmd_valid;
    logic                             cmd_ready;

    modport master (
        output sample_data, sample_valid, cmd_addr, cmd_data, cmd_valid,
        input  sample_ready, cmd_ready
    );

    modport slave (
        input  sample_data, sample_valid, cmd_addr, cmd_data, cmd_valid,
        output sample_ready, cmd_ready
    );
endinterface

// File: rtl/ac97_frame_packer.sv
// ac97_frame_packer: serializes AC97 SDATA_OUT/SYNC frames; define AC97_UNDERRUN_COUNT_EN to build the underrun counter.
module ac97_frame_packer #(
    parameter int CHANNELS     = 2,
    parameter int SAMPLE_WIDTH = 20
) (
    input  logic               bit_clk,
    input  logic               reset_b,
    ac97_frame_packer_if.slave bus,
    output logic               sync,
    output logic               sdata_out,
    output logic [15:0]        underrun_count
);
    localparam int SW = SAMPLE_WIDTH;
    localparam int DW = CHANNELS * SW;
    localparam int SLOT_OF [6] = '{3, 4, 7, 8, 6, 9};

    function automatic int chan_of(input int n);
        chan_of = -1;
        for (int c = 0; c < CHANNELS; c++) if (SLOT_OF[c] == n) chan_of = c;
    endfunction

    function automatic logic [15:0] pcm_tag();
        pcm_tag = 16'h8000;
        for (int c = 0; c < CHANNELS; c++) pcm_tag |= 16'h8000 >> SLOT_OF[c];
    endfunction

    localparam logic [15:0] PCM_TAG = pcm_tag();

    logic [7:0]        cnt;
    logic [DW-1:0]     held;
    logic [DW-1:0]     smp;
    logic [254:0]      shift;
    logic [11:0][19:0] slot;
    logic [15:0]       tag;
    logic [255:0]      frame;
    logic              edge_255;
    logic              s_xfer;
    logic              c_xfer;

    assign edge_255         = cnt == 8'hff;
    assign bus.sample_ready = edge_255;
    assign bus.cmd_ready    = edge_255;
    assign s_xfer           = bus.sample_valid && edge_255;
    assign c_xfer           = bus.cmd_valid && edge_255;
    assign smp              = s_xfer ? bus.sample_data : held;

    // Frame is assembled combinationally and captured whole at the cnt==255 edge.
    assign tag      = PCM_TAG | {1'b0, c_xfer, c_xfer, 13'b0};
    assign slot[11] = c_xfer ? {1'b0, bus.cmd_addr, 12'b0} : 20'b0;
    assign slot[10] = c_xfer ? {bus.cmd_data, 4'b0} : 20'b0;
    assign frame    = {tag, slot};

    for (genvar s = 3; s <= 12; s++) begin : g_slot
        localparam int C = chan_of(s);
        if (C >= 0) begin : g_pcm
            assign slot[12-s] = 20'(smp[C*SW +: SW]) << (20 - SW);
        end else begin : g_zero
            assign slot[12-s] = 20'b0;
        end
    end

    always_ff @(posedge bit_clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt       <= 8'hff;
            sync      <= 1'b0;
            sdata_out <= 1'b0;
            shift     <= '0;
            held      <= '0;
        end else begin
            cnt       <= cnt + 8'd1;
            sync      <= edge_255 || cnt < 8'd15;
            sdata_out <= edge_255 ? frame[255] : shift[254];
            shift     <= edge_255 ? frame[254:0] : {shift[253:0], 1'b0};
            if (s_xfer) held <= bus.sample_data;
        end
    end

`ifdef AC97_UNDERRUN_COUNT_EN
    logic primed;

    // Frames before the first sample transfer carry reset zeros and are not underruns.
    always_ff @(posedge bit_clk or negedge reset_b) begin
        if (!reset_b) begin
            primed         <= 1'b0;
            underrun_count <= 16'h0000;
        end else if (edge_255) begin
            if (s_xfer) primed <= 1'b1;
            else if (primed && underrun_count != 16'hffff) underrun_count <= underrun_count + 16'd1;
        end
    end
`else
    assign underrun_count = 16'h0000;
`endif
endmodule
